// File: rtl/pic_int_sequencer_pkg.sv
// Shared types and helpers for the 8259 interrupt-acknowledge sequencer:
// FSM state encoding, reset constants and rotating-priority search functions.
package pic_int_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK1,
        ST_WAIT2,
        ST_ACK2
    } pic_state_e;

    localparam logic [2:0] SPURIOUS_DEFAULT = 3'd7;
    localparam logic [2:0] LP_RESET         = 3'd7;

    // Returns {found, idx} for the highest-priority set bit, where level
    // (lp+1)%8 is highest and priority descends cyclically down to lp.
    function automatic logic [3:0] rot_first(input logic [7:0] vec, input logic [2:0] lp);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = lp + 3'd1 + k[2:0];
            if (vec[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Position of a level in the current priority order (0 = highest).
    function automatic logic [2:0] prio_rank(input logic [2:0] idx, input logic [2:0] lp);
        return idx - lp - 3'd1;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational priority resolver: highest unmasked request that strictly
// outranks every level currently in service.
module pic_priority_resolver
    import pic_int_sequencer_pkg::*;
(
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic [7:0] isr,
    input  logic [2:0] lp,
    output logic       req_valid,
    output logic [2:0] req_idx
);

    logic [3:0] req_hit;
    logic [3:0] isr_hit;

    assign req_hit = rot_first(irr & ~imr, lp);
    assign isr_hit = rot_first(isr, lp);

    assign req_idx   = req_hit[2:0];
    assign req_valid = req_hit[3] &&
                       (!isr_hit[3] || (prio_rank(req_hit[2:0], lp) < prio_rank(isr_hit[2:0], lp)));

endmodule

// File: rtl/pic_int_sequencer.sv
// 8259 interrupt-acknowledge sequencer: raises INT, runs the 8086 two-pulse
// INTA cycle, maintains ISR and rotating priority, and services EOI commands.
module pic_int_sequencer
    import pic_int_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int SPURIOUS_IDX = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic [4:0] vector_base,
    input  logic       aeoi,
    input  logic       rotate_mode,
    input  logic       eoi_strobe,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       inta_n,
    output logic       int_out,
    output logic       ack_valid,
    output logic [2:0] ack_idx,
    output logic [7:0] isr,
    output logic [7:0] data_out,
    output logic       data_oe
);

    localparam logic [2:0] SPUR_IDX = SPURIOUS_IDX[2:0];

    pic_state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic       inta_prev_q;
    logic       inta_s;
    logic       inta_fall;
    logic       inta_rise;

    logic       int_out_q, int_out_d;
    logic       ack_valid_q, ack_valid_d;
    logic [2:0] ack_idx_q, ack_idx_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] lp_q, lp_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;
    logic       spurious_q, spurious_d;

    logic       req_valid;
    logic [2:0] req_idx;
    logic       eoi_valid;
    logic [2:0] eoi_idx;

    pic_priority_resolver u_req_resolver (
        .irr       (irr),
        .imr       (imr),
        .isr       (isr_q),
        .lp        (lp_q),
        .req_valid (req_valid),
        .req_idx   (req_idx)
    );

    // Non-specific EOI target: highest-priority in-service level.
    pic_priority_resolver u_eoi_resolver (
        .irr       (isr_q),
        .imr       (8'h00),
        .isr       (8'h00),
        .lp        (lp_q),
        .req_valid (eoi_valid),
        .req_idx   (eoi_idx)
    );

    assign inta_s    = sync_q[SYNC_STAGES-1];
    assign inta_fall = inta_prev_q && !inta_s;
    assign inta_rise = !inta_prev_q && inta_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '1;
            inta_prev_q <= 1'b1;
            state_q     <= ST_IDLE;
            int_out_q   <= 1'b0;
            ack_valid_q <= 1'b0;
            ack_idx_q   <= 3'd0;
            isr_q       <= 8'h00;
            lp_q        <= LP_RESET;
            data_out_q  <= 8'h00;
            data_oe_q   <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], inta_n};
            inta_prev_q <= inta_s;
            state_q     <= state_d;
            int_out_q   <= int_out_d;
            ack_valid_q <= ack_valid_d;
            ack_idx_q   <= ack_idx_d;
            isr_q       <= isr_d;
            lp_q        <= lp_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            spurious_q  <= spurious_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        int_out_d   = 1'b0;
        ack_valid_d = 1'b0;
        ack_idx_d   = ack_idx_q;
        isr_d       = isr_q;
        lp_d        = lp_q;
        data_out_d  = data_out_q;
        data_oe_d   = 1'b0;
        spurious_d  = spurious_q;

        // EOI clears land before any ACK1 set so a same-bit set wins.
        if (eoi_strobe) begin
            if (eoi_specific) begin
                isr_d[eoi_level] = 1'b0;
                if (rotate_mode) lp_d = eoi_level;
            end else if (eoi_valid) begin
                isr_d[eoi_idx] = 1'b0;
                if (rotate_mode) lp_d = eoi_idx;
            end
        end

        case (state_q)
            ST_IDLE: begin
                int_out_d = req_valid;
                if (inta_fall) begin
                    state_d   = ST_ACK1;
                    int_out_d = 1'b0;
                    if (req_valid) begin
                        ack_idx_d      = req_idx;
                        isr_d[req_idx] = 1'b1;
                        ack_valid_d    = 1'b1;
                        spurious_d     = 1'b0;
                    end else begin
                        ack_idx_d  = SPUR_IDX;
                        spurious_d = 1'b1;
                    end
                end
            end
            ST_ACK1: begin
                if (inta_rise) state_d = ST_WAIT2;
            end
            ST_WAIT2: begin
                if (inta_fall) begin
                    state_d    = ST_ACK2;
                    data_oe_d  = 1'b1;
                    data_out_d = {vector_base, ack_idx_q};
                end
            end
            ST_ACK2: begin
                data_oe_d  = 1'b1;
                data_out_d = {vector_base, ack_idx_q};
                if (inta_rise) begin
                    state_d   = ST_IDLE;
                    data_oe_d = 1'b0;
                    if (aeoi && !spurious_q) begin
                        isr_d[ack_idx_q] = 1'b0;
                        if (rotate_mode) lp_d = ack_idx_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign int_out   = int_out_q;
    assign ack_valid = ack_valid_q;
    assign ack_idx   = ack_idx_q;
    assign isr       = isr_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Directed bench for pic_int_sequencer: INTA sequencing, priority, EOI,
// rotation, spurious requests, auto-EOI and mid-cycle reset.
module tb_pic_int_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irr;
    logic [7:0] imr;
    logic [4:0] vector_base;
    logic       aeoi;
    logic       rotate_mode;
    logic       eoi_strobe;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       inta_n;
    logic       int_out;
    logic       ack_valid;
    logic [2:0] ack_idx;
    logic [7:0] isr;
    logic [7:0] data_out;
    logic       data_oe;

    int errors = 0;
    int checks = 0;
    int ack_cnt = 0;
    int ack_snap;

    pic_int_sequencer #(
        .SYNC_STAGES  (2),
        .SPURIOUS_IDX (7)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irr          (irr),
        .imr          (imr),
        .vector_base  (vector_base),
        .aeoi         (aeoi),
        .rotate_mode  (rotate_mode),
        .eoi_strobe   (eoi_strobe),
        .eoi_specific (eoi_specific),
        .eoi_level    (eoi_level),
        .inta_n       (inta_n),
        .int_out      (int_out),
        .ack_valid    (ack_valid),
        .ack_idx      (ack_idx),
        .isr          (isr),
        .data_out     (data_out),
        .data_oe      (data_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && ack_valid) ack_cnt <= ack_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Two-flop synchroniser plus edge register: an inta_n edge is acted on
    // at the third clock edge after it is driven.
    task automatic inta_low();
        inta_n = 1'b0;
        tick(3);
    endtask

    task automatic inta_high();
        inta_n = 1'b1;
        tick(3);
    endtask

    task automatic eoi(input logic specific, input logic [2:0] lvl);
        eoi_specific = specific;
        eoi_level    = lvl;
        eoi_strobe   = 1'b1;
        tick(1);
        eoi_strobe   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irr = 8'h00; imr = 8'h00; vector_base = 5'h08;
        aeoi = 1'b0; rotate_mode = 1'b0; eoi_strobe = 1'b0;
        eoi_specific = 1'b0; eoi_level = 3'd0; inta_n = 1'b1;
        tick(3);
        chk("rst_int_out", {7'd0, int_out}, 8'h00);
        chk("rst_ack_valid", {7'd0, ack_valid}, 8'h00);
        chk("rst_ack_idx", {5'd0, ack_idx}, 8'h00);
        chk("rst_isr", isr, 8'h00);
        chk("rst_data", data_out, 8'h00);
        chk("rst_data_oe", {7'd0, data_oe}, 8'h00);
        rst_n = 1'b1;
        tick(2);

        // 1: basic two-pulse acknowledge of IR2 among IR2/IR5
        irr = 8'h24;
        tick(2);
        chk("t1_int_out", {7'd0, int_out}, 8'h01);
        ack_snap = ack_cnt;
        inta_low();
        chk("t1_ack_valid", {7'd0, ack_valid}, 8'h01);
        chk("t1_ack_idx", {5'd0, ack_idx}, 8'h02);
        chk("t1_isr", isr, 8'h04);
        chk("t1_int_drop", {7'd0, int_out}, 8'h00);
        irr = 8'h00;
        inta_high();
        inta_low();
        chk("t1_data_oe", {7'd0, data_oe}, 8'h01);
        chk("t1_data", data_out, 8'h42);
        inta_high();
        chk("t1_data_oe_off", {7'd0, data_oe}, 8'h00);
        chk("t1_ack_once", 8'(ack_cnt - ack_snap), 8'h01);
        tick(1);
        chk("t1_isr_hold", isr, 8'h04);

        // 2: IR0 outranks IR2 in service; IR3 waits for non-specific EOI
        irr = 8'h09;
        tick(2);
        chk("t2_int_ir0", {7'd0, int_out}, 8'h01);
        imr = 8'h01;
        tick(2);
        chk("t2_ir3_blocked", {7'd0, int_out}, 8'h00);
        eoi(1'b0, 3'd0);
        chk("t2_eoi_isr", isr, 8'h00);
        tick(1);
        chk("t2_int_ir3", {7'd0, int_out}, 8'h01);
        irr = 8'h00; imr = 8'h00;
        tick(2);
        chk("t2_idle", {7'd0, int_out}, 8'h00);

        // 3: rotation after servicing IR4 makes IR5 highest
        rotate_mode = 1'b1;
        irr = 8'h10;
        tick(2);
        inta_low();
        chk("t3_ack4", {5'd0, ack_idx}, 8'h04);
        irr = 8'h00;
        inta_high();
        inta_low();
        inta_high();
        eoi(1'b0, 3'd0);
        chk("t3_eoi_isr", isr, 8'h00);
        irr = 8'h21;
        tick(2);
        chk("t3_int", {7'd0, int_out}, 8'h01);
        inta_low();
        chk("t3_ack5", {5'd0, ack_idx}, 8'h05);
        chk("t3_isr", isr, 8'h20);
        irr = 8'h01;
        inta_high();
        inta_low();
        chk("t3_data", data_out, 8'h45);
        inta_high();
        tick(1);
        chk("t3_ir0_blocked", {7'd0, int_out}, 8'h00);
        eoi(1'b1, 3'd5);
        chk("t3_spec_eoi", isr, 8'h00);
        irr = 8'h00;
        rotate_mode = 1'b0;
        tick(2);

        // 4: request withdrawn before first INTA gives spurious IR7
        irr = 8'h10;
        tick(2);
        chk("t4_int", {7'd0, int_out}, 8'h01);
        ack_snap = ack_cnt;
        irr = 8'h00;
        inta_low();
        chk("t4_spur_idx", {5'd0, ack_idx}, 8'h07);
        chk("t4_isr", isr, 8'h00);
        chk("t4_no_ack", {7'd0, ack_valid}, 8'h00);
        inta_high();
        inta_low();
        chk("t4_data", data_out, 8'h47);
        chk("t4_data_oe", {7'd0, data_oe}, 8'h01);
        inta_high();
        chk("t4_ack_cnt", 8'(ack_cnt - ack_snap), 8'h00);
        chk("t4_isr_end", isr, 8'h00);

        // 5: auto-EOI clears IR7 at the end of the second pulse
        aeoi = 1'b1;
        irr = 8'h80;
        tick(2);
        inta_low();
        chk("t5_ack7", {5'd0, ack_idx}, 8'h07);
        chk("t5_isr_set", isr, 8'h80);
        irr = 8'h02;
        inta_high();
        inta_low();
        chk("t5_isr_held", isr, 8'h80);
        inta_high();
        chk("t5_isr_clr", isr, 8'h00);
        tick(1);
        chk("t5_int_reassert", {7'd0, int_out}, 8'h01);

        // 6: reset during WAIT2 aborts; lp returns to 7 so IR0 beats IR7
        inta_low();
        chk("t6_ack1", {5'd0, ack_idx}, 8'h01);
        chk("t6_isr", isr, 8'h02);
        inta_high();
        rst_n = 1'b0;
        #2;
        chk("t6_rst_int", {7'd0, int_out}, 8'h00);
        chk("t6_rst_ack_idx", {5'd0, ack_idx}, 8'h00);
        chk("t6_rst_isr", isr, 8'h00);
        chk("t6_rst_data", data_out, 8'h00);
        chk("t6_rst_oe", {7'd0, data_oe}, 8'h00);
        tick(2);
        rst_n = 1'b1;
        aeoi = 1'b0;
        irr = 8'h81;
        tick(2);
        chk("t6_int", {7'd0, int_out}, 8'h01);
        inta_low();
        chk("t6_ack0", {5'd0, ack_idx}, 8'h00);
        chk("t6_isr_new", isr, 8'h01);
        irr = 8'h80;
        inta_high();
        inta_low();
        chk("t6_data", data_out, 8'h40);
        inta_high();
        chk("t6_oe_off", {7'd0, data_oe}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
